// File: rtl/iob_eth_pkg.sv
// Shared definitions for the Ethernet IOb glue: bridge FSM encodings and the
// timeout terminal-count helper.
// Latency: n/a (package). Backpressure: n/a (package).
package iob_eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_ACK   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } wbm2iob_state_t;

    // Terminal count of a w-bit timeout counter: all ones.
    function automatic int timeout_tc(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/iob_reg.sv
// Generic register with synchronous active-high reset and load enable.
// Latency: 1 cycle from d to q when en is high.
// Backpressure: none; holds q while en is low.
module iob_reg #(
    parameter int              DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/iob_eth_wbm2iob.sv
// Wishbone slave to IOb master bridge for the MAC DMA port, one transfer at a time.
// Latency: stb to ack is 3 cycles minimum (capture, IOb request, ack).
// Backpressure: wb_ack_o withheld until m_ready_i; IOb requests are never aborted.
//
// Ports: Wishbone slave side (wb_*), IOb master side (m_*), clk/rst synchronous.
// Optional feature: define ETH_WBM2IOB_TIMEOUT_EN to enable a TIMEOUT_W-bit
// request timeout that ends a stalled transfer with a one-cycle wb_err_o.
module iob_eth_wbm2iob
    import iob_eth_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         wb_adr_i,
    input  logic [DATA_W/8-1:0] wb_sel_i,
    input  logic                wb_we_i,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                m_valid_o,
    output logic [ADDR_W-1:0]   m_address_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_ready_i
);

    localparam int STRB_W = DATA_W / 8;

    wbm2iob_state_t state_q, state_d;

    logic              new_req;
    logic              rd_capture;
    logic [STRB_W-1:0] strb_d;

    assign new_req = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign strb_d  = wb_we_i ? wb_sel_i : '0;
    // Read data is only taken when the cycle is still alive and it was a read;
    // writes and abandoned (drained) cycles leave wb_dat_o untouched.
    assign rd_capture = (state_q == ST_REQ) && m_ready_i && wb_cyc_i
                        && (m_wstrb_o == '0);

    iob_reg #(.DATA_W(ADDR_W)) u_adr_reg (
        .clk(clk), .rst(rst), .en(new_req),
        .d(wb_adr_i[ADDR_W-1:0]), .q(m_address_o)
    );

    iob_reg #(.DATA_W(DATA_W)) u_wdata_reg (
        .clk(clk), .rst(rst), .en(new_req), .d(wb_dat_i), .q(m_wdata_o)
    );

    iob_reg #(.DATA_W(STRB_W)) u_wstrb_reg (
        .clk(clk), .rst(rst), .en(new_req), .d(strb_d), .q(m_wstrb_o)
    );

    iob_reg #(.DATA_W(DATA_W)) u_rdata_reg (
        .clk(clk), .rst(rst), .en(rd_capture), .d(m_rdata_i), .q(wb_dat_o)
    );

`ifdef ETH_WBM2IOB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TO_TC = TIMEOUT_W'(timeout_tc(TIMEOUT_W));

    logic [TIMEOUT_W-1:0] to_cnt;
    logic                 to_hit;

    // Counter equals the index of the current REQ cycle (0 on entry).
    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (new_req) begin
            to_cnt <= '0;
        end else if ((state_q == ST_REQ) && !m_ready_i) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (state_q == ST_REQ) && (to_cnt == TO_TC);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        m_valid_o = 1'b0;
        wb_ack_o  = 1'b0;
        wb_err_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (new_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                m_valid_o = 1'b1;
                // Completion beats a dropped cycle or a timeout in the same cycle.
                if (m_ready_i) begin
                    state_d = wb_cyc_i ? ST_ACK : ST_IDLE;
                end else if (!wb_cyc_i) begin
                    state_d = ST_DRAIN;
`ifdef ETH_WBM2IOB_TIMEOUT_EN
                end else if (to_hit) begin
                    state_d = ST_ERR;
`endif
                end
            end
            ST_ACK: begin
                wb_ack_o = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_DRAIN: begin
                m_valid_o = 1'b1;
                if (m_ready_i) state_d = ST_IDLE;
            end
`ifdef ETH_WBM2IOB_TIMEOUT_EN
            ST_ERR: begin
                wb_err_o = 1'b1;
                state_d  = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_iob_eth_wbm2iob.sv
// Directed bench for the Wishbone to IOb bridge: per-cycle expected outputs
// are derived from the transfer being driven, checked on the falling edge.
// Build with ETH_WBM2IOB_TIMEOUT_EN defined to add the timeout scenarios.
module tb_iob_eth_wbm2iob;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        m_valid_o;
    logic [31:0] m_address_o;
    logic [31:0] m_wdata_o;
    logic [3:0]  m_wstrb_o;
    logic [31:0] m_rdata_i;
    logic        m_ready_i;

    iob_eth_wbm2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .m_valid_o(m_valid_o), .m_address_o(m_address_o), .m_wdata_o(m_wdata_o),
        .m_wstrb_o(m_wstrb_o), .m_rdata_i(m_rdata_i), .m_ready_i(m_ready_i)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc_cnt    = 0;
    int ack_seen   = 0;
    int err_seen   = 0;
    bit chk_en     = 1'b0;

    // Expected DUT outputs for the current cycle.
    logic        exp_valid, exp_ack, exp_err;
    logic [31:0] exp_adr, exp_wdata, exp_dat;
    logic [3:0]  exp_wstrb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h, expected %h", nm, cyc_cnt, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid",   32'(m_valid_o),   32'(exp_valid));
            chk("m_address", m_address_o,      exp_adr);
            chk("m_wdata",   m_wdata_o,        exp_wdata);
            chk("m_wstrb",   32'(m_wstrb_o),   32'(exp_wstrb));
            chk("wb_ack",    32'(wb_ack_o),    32'(exp_ack));
            chk("wb_err",    32'(wb_err_o),    32'(exp_err));
            chk("wb_dat",    wb_dat_o,         exp_dat);
            if (wb_ack_o === 1'b1) ack_seen++;
            if (wb_err_o === 1'b1) err_seen++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc_cnt++;
    endtask

    task automatic idle_inputs();
        wb_cyc_i  = 1'b0;
        wb_stb_i  = 1'b0;
        wb_we_i   = 1'b0;
        m_ready_i = 1'b0;
    endtask

    // Entered at the start of a cycle in which the bridge should be idle.
    // rdy_dly: REQ cycle index in which m_ready_i is driven high.
    // drop_at: REQ cycle index in which cyc/stb are dropped (-1 = never).
    // keep:    hold stb in the ack cycle while presenting nxt_adr.
    task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [31:0] rdata,
                           input int rdy_dly, input int drop_at,
                           input bit keep, input logic [31:0] nxt_adr,
                           output int lat);
        bit aborted = 1'b0;
        int t0;
        logic [3:0] strb;
        strb = we ? sel : 4'h0;
        lat  = 0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = adr; wb_we_i = we;
        wb_sel_i = sel;  wb_dat_i = dat;  m_ready_i = 1'b0;
        t0 = cyc_cnt;
        for (int j = 0; j <= rdy_dly; j++) begin
            step();
            exp_valid = 1'b1; exp_adr = adr; exp_wdata = dat; exp_wstrb = strb;
            exp_ack = 1'b0;
            if (j == drop_at) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0; aborted = 1'b1;
            end
            m_ready_i = (j == rdy_dly);
            m_rdata_i = m_ready_i ? rdata : (32'hBAD0_0000 + 32'(j));
        end
        step();
        exp_valid = 1'b0;
        if (!aborted) begin
            exp_ack = 1'b1;
            if (strb == 4'h0) exp_dat = rdata;
            lat = cyc_cnt - t0 + 1;
        end
        // Ready in the ack cycle must be ignored.
        m_ready_i = 1'b1;
        m_rdata_i = 32'hFFFF_FFFF;
        if (keep && !aborted) wb_adr_i = nxt_adr;
        else begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
        step();
        exp_ack   = 1'b0;
        m_ready_i = 1'b0;
    endtask

    int lat;
    int acks0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0; m_rdata_i = '0;
        exp_valid = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
        exp_adr = '0; exp_wdata = '0; exp_wstrb = '0; exp_dat = '0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        // Ready while idle must be ignored.
        m_ready_i = 1'b1; m_rdata_i = 32'h5555_AAAA;
        step();
        m_ready_i = 1'b0;
        step();

        // Read with ready in the first REQ cycle.
        acks0 = ack_seen;
        do_xfer(32'h0000_1000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, -1, 1'b0, 32'h0, lat);
        chk("read_latency", 32'(lat), 32'd3);
        chk("read_dat_lit", wb_dat_o, 32'hDEAD_BEEF);
        chk("read_acks", 32'(ack_seen - acks0), 32'd1);

        // Write, ready after 5 cycles; stb held through ack with a new address.
        acks0 = ack_seen;
        do_xfer(32'h0000_0200, 1'b1, 4'h3, 32'h1234_5678, 32'h7777_7777, 5, -1,
                1'b1, 32'h0000_2000, lat);
        chk("write_acks", 32'(ack_seen - acks0), 32'd1);
        chk("write_dat_lit", wb_dat_o, 32'hDEAD_BEEF);
        chk("write_wstrb_lit", 32'(m_wstrb_o), 32'h3);

        // Strobe presented during ack is accepted in the following idle cycle.
        do_xfer(32'h0000_2000, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D, 1, -1, 1'b0, 32'h0, lat);
        chk("b2b_dat_lit", wb_dat_o, 32'hCAFE_F00D);

        // Abort: cyc dropped 2 cycles into REQ, ready 4 cycles later.
        acks0 = ack_seen;
        do_xfer(32'h0000_3000, 1'b0, 4'hF, 32'h0, 32'h1111_2222, 6, 2, 1'b0, 32'h0, lat);
        chk("abort_acks", 32'(ack_seen - acks0), 32'd0);
        chk("abort_dat_lit", wb_dat_o, 32'hCAFE_F00D);

        // Reset during REQ.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hC;
        wb_adr_i = 32'h0000_4000; wb_dat_i = 32'hA5A5_A5A5;
        step();
        exp_valid = 1'b1; exp_adr = 32'h0000_4000; exp_wdata = 32'hA5A5_A5A5; exp_wstrb = 4'hC;
        rst = 1'b1;
        idle_inputs();
        step();
        exp_valid = 1'b0; exp_adr = '0; exp_wdata = '0; exp_wstrb = '0; exp_dat = '0;
        rst = 1'b0;
        step();
        do_xfer(32'h0000_0044, 1'b0, 4'hF, 32'h0, 32'h0BAD_CAFE, 2, -1, 1'b0, 32'h0, lat);
        chk("post_rst_dat_lit", wb_dat_o, 32'h0BAD_CAFE);
        chk("post_rst_latency", 32'(lat), 32'd5);

`ifdef ETH_WBM2IOB_TIMEOUT_EN
        // Ready on the terminal count (REQ cycle 15) wins.
        acks0 = ack_seen;
        do_xfer(32'h0000_5000, 1'b0, 4'hF, 32'h0, 32'h1357_9BDF, 15, -1, 1'b0, 32'h0, lat);
        chk("race_acks", 32'(ack_seen - acks0), 32'd1);
        chk("race_errs", 32'(err_seen), 32'd0);

        // No ready: err pulses once after the terminal count, valid drops.
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 32'h0000_6000; wb_dat_i = 32'h0;
        for (int j = 0; j < 16; j++) begin
            step();
            exp_valid = 1'b1; exp_adr = 32'h0000_6000; exp_wdata = 32'h0; exp_wstrb = 4'h0;
        end
        step();
        exp_valid = 1'b0; exp_err = 1'b1;
        idle_inputs();
        step();
        exp_err = 1'b0;
        step();
        chk("timeout_errs", 32'(err_seen), 32'd1);
`else
        // Without the timeout a long wait still completes normally.
        do_xfer(32'h0000_7000, 1'b0, 4'hF, 32'h0, 32'h2468_ACE0, 40, -1, 1'b0, 32'h0, lat);
        chk("long_wait_latency", 32'(lat), 32'd43);
        chk("no_errs", 32'(err_seen), 32'd0);
`endif
        step();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
